// File: rtl/aibcr3_scan_seq_ctrl_if.sv
// Command/response handshake between an ATPG pattern source and the scan sequencer.
interface aibcr3_scan_seq_ctrl_if #(
    parameter int CHAIN_LEN = 32
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_capture;
    logic [4*CHAIN_LEN-1:0] cmd_pattern;
    logic                   abort;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [4*CHAIN_LEN-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_capture, cmd_pattern, abort, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  cmd_valid, cmd_capture, cmd_pattern, abort, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/aibcr3_scan_seq_ctrl.sv
// ATPG scan sequencer: shifts one 4-segment pattern into the boundary-scan segments,
// collects the returned bits, optionally pulses capture, and returns the unloaded data.
module aibcr3_scan_seq_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    aibcr3_scan_seq_ctrl_if.slave        ctl,
    output logic                         iatpg_scan_mode_n,
    output logic                         buf_iatpg_bsr_scan_shift_n,
    output logic                         buf_iatpg_bsr0_scan_in,
    output logic                         buf_iatpg_bsr1_scan_in,
    output logic                         buf_iatpg_bsr2_scan_in,
    output logic                         buf_iatpg_bsr3_scan_in,
    output logic                         buf_iatpg_bsr0_scan_shift_clk,
    output logic                         buf_iatpg_bsr1_scan_shift_clk,
    output logic                         buf_iatpg_bsr2_scan_shift_clk,
    output logic                         buf_iatpg_bsr3_scan_shift_clk,
    input  logic                         scan_out_seg0,
    input  logic                         scan_out_seg1,
    input  logic                         scan_out_seg2,
    input  logic                         scan_out_seg3
);
    localparam int IDX_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, HOLD, CAP_HI, CAP_LO, DONE
    } state_t;

    state_t               state_reg, state_next;
    logic                 phase_reg, phase_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 cap_reg, cap_next;
    logic [CHAIN_LEN-1:0] pat_reg [4];
    logic [CHAIN_LEN-1:0] pat_next [4];
    logic [CHAIN_LEN-1:0] data_reg [4];
    logic [CHAIN_LEN-1:0] data_next [4];
    logic [3:0]           scan_in_reg, scan_in_next;
    logic                 shift_clk_reg, shift_clk_next;
    logic                 shift_n_reg, shift_n_next;
    logic                 mode_n_reg, mode_n_next;
    logic                 rsp_valid_reg, rsp_valid_next;
    logic                 cmd_ready_reg, cmd_ready_next;
    logic                 load_next;
    logic [3:0]           scan_out_vec;
    logic [IDX_W-1:0]     cnt_idx, cnt_next_idx;

    assign scan_out_vec = {scan_out_seg3, scan_out_seg2, scan_out_seg1, scan_out_seg0};
    assign cnt_idx      = cnt_reg[IDX_W-1:0];
    assign cnt_next_idx = cnt_next[IDX_W-1:0];

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        cap_next   = cap_reg;
        for (int s = 0; s < 4; s++) begin
            pat_next[s]  = pat_reg[s];
            data_next[s] = data_reg[s];
        end

        // The return bit of period i is taken at the end of its low phase.
        if (state_reg == SHIFT && !phase_reg) begin
            for (int s = 0; s < 4; s++) begin
                data_next[s][cnt_idx] = scan_out_vec[s];
            end
        end

        if (ctl.abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ctl.cmd_valid && cmd_ready_reg) begin
                        for (int s = 0; s < 4; s++) begin
                            pat_next[s] = ctl.cmd_pattern[s*CHAIN_LEN +: CHAIN_LEN];
                        end
                        cap_next   = ctl.cmd_capture;
                        cnt_next   = '0;
                        phase_next = 1'b0;
                        state_next = SETUP;
                    end
                end
                SETUP: begin
                    cnt_next   = '0;
                    phase_next = 1'b0;
                    state_next = SHIFT;
                end
                SHIFT: begin
                    if (!phase_reg) begin
                        phase_next = 1'b1;
                    end else begin
                        phase_next = 1'b0;
                        if (cnt_reg == LAST) begin
                            state_next = HOLD;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                HOLD:    state_next = cap_reg ? CAP_HI : DONE;
                CAP_HI:  state_next = CAP_LO;
                CAP_LO:  state_next = DONE;
                DONE: begin
                    if (ctl.rsp_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // Outputs are registered images of the state being entered.
        mode_n_next    = (state_next == IDLE);
        cmd_ready_next = (state_next == IDLE);
        rsp_valid_next = (state_next == DONE);
        load_next      = (state_next == SETUP) || (state_next == SHIFT);
        shift_n_next   = !load_next;
        shift_clk_next = ((state_next == SHIFT) && phase_next) || (state_next == CAP_HI);
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_seg
            assign scan_in_next[gi] = load_next & pat_next[gi][cnt_next_idx];
            assign ctl.rsp_data[gi*CHAIN_LEN +: CHAIN_LEN] = data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= 1'b0;
            cnt_reg       <= '0;
            cap_reg       <= 1'b0;
            scan_in_reg   <= '0;
            shift_clk_reg <= 1'b0;
            shift_n_reg   <= 1'b1;
            mode_n_reg    <= 1'b1;
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            for (int s = 0; s < 4; s++) begin
                pat_reg[s]  <= '0;
                data_reg[s] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            cnt_reg       <= cnt_next;
            cap_reg       <= cap_next;
            scan_in_reg   <= scan_in_next;
            shift_clk_reg <= shift_clk_next;
            shift_n_reg   <= shift_n_next;
            mode_n_reg    <= mode_n_next;
            rsp_valid_reg <= rsp_valid_next;
            cmd_ready_reg <= cmd_ready_next;
            for (int s = 0; s < 4; s++) begin
                pat_reg[s]  <= pat_next[s];
                data_reg[s] <= data_next[s];
            end
        end
    end

    assign ctl.cmd_ready                 = cmd_ready_reg;
    assign ctl.rsp_valid                 = rsp_valid_reg;
    assign iatpg_scan_mode_n             = mode_n_reg;
    assign buf_iatpg_bsr_scan_shift_n    = shift_n_reg;
    assign buf_iatpg_bsr0_scan_in        = scan_in_reg[0];
    assign buf_iatpg_bsr1_scan_in        = scan_in_reg[1];
    assign buf_iatpg_bsr2_scan_in        = scan_in_reg[2];
    assign buf_iatpg_bsr3_scan_in        = scan_in_reg[3];
    assign buf_iatpg_bsr0_scan_shift_clk = shift_clk_reg;
    assign buf_iatpg_bsr1_scan_shift_clk = shift_clk_reg;
    assign buf_iatpg_bsr2_scan_shift_clk = shift_clk_reg;
    assign buf_iatpg_bsr3_scan_shift_clk = shift_clk_reg;
endmodule

// File: tb/tb_aibcr3_scan_seq_ctrl.sv
// Scoreboard bench: four external scan chains are modelled as shift registers; each
// response must equal the chain contents at command acceptance, at the expected latency.
module tb_aibcr3_scan_seq_ctrl;
    localparam int L  = 4;
    localparam int CW = 3;
    localparam int PW = 4 * L;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aibcr3_scan_seq_ctrl_if #(.CHAIN_LEN(L)) ctl ();

    logic       mode_n, shift_n;
    logic [3:0] sin, sclk, sout;

    aibcr3_scan_seq_ctrl #(.CHAIN_LEN(L), .CNT_W(CW)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .ctl                           (ctl),
        .iatpg_scan_mode_n             (mode_n),
        .buf_iatpg_bsr_scan_shift_n    (shift_n),
        .buf_iatpg_bsr0_scan_in        (sin[0]),
        .buf_iatpg_bsr1_scan_in        (sin[1]),
        .buf_iatpg_bsr2_scan_in        (sin[2]),
        .buf_iatpg_bsr3_scan_in        (sin[3]),
        .buf_iatpg_bsr0_scan_shift_clk (sclk[0]),
        .buf_iatpg_bsr1_scan_shift_clk (sclk[1]),
        .buf_iatpg_bsr2_scan_shift_clk (sclk[2]),
        .buf_iatpg_bsr3_scan_shift_clk (sclk[3]),
        .scan_out_seg0                 (sout[0]),
        .scan_out_seg1                 (sout[1]),
        .scan_out_seg2                 (sout[2]),
        .scan_out_seg3                 (sout[3])
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // External chain model: scan_out is bit 0, a rising shift clock in shift mode moves
    // scan_in into the top; a rising edge with shift_n=1 (capture) leaves the chain as is.
    logic [L-1:0] chain [4];
    logic [L-1:0] preload_val [4];
    logic         preload_en = 1'b0;
    logic [3:0]   sclk_prev  = '0;
    int           rises      = 0;
    int           cap_hi     = 0;
    logic         rise_sin[$];

    for (genvar gi = 0; gi < 4; gi++) begin : g_out
        assign sout[gi] = chain[gi][0];
    end

    always @(negedge clk) begin
        if (preload_en) begin
            for (int s = 0; s < 4; s++) chain[s] <= preload_val[s];
        end else begin
            for (int s = 0; s < 4; s++)
                if (sclk[s] && !sclk_prev[s] && !shift_n)
                    chain[s] <= {sin[s], chain[s][L-1:1]};
        end
        sclk_prev <= sclk;
        if (sclk[0] && !sclk_prev[0]) begin
            rises <= rises + 1;
            if (!shift_n) rise_sin.push_back(sin[0]);
            else          cap_hi <= cap_hi + 1;
        end
    end

    typedef struct {
        logic [PW-1:0] data;
        int            acc;
        bit            cap;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: pops one expectation when rsp_valid rises, then demands stability.
    logic          prev_v = 1'b0;
    logic [PW-1:0] last_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            check("shift_clk_equal", 64'(sclk), 64'({4{sclk[0]}}));
            if (ctl.rsp_valid) begin
                check("busy_cmd_ready", 64'(ctl.cmd_ready), 64'd0);
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 64'(ctl.rsp_valid), 64'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rsp_data", 64'(ctl.rsp_data), 64'(e.data));
                        check("latency", 64'(cyc - e.acc), 64'(2 * L + 2 + (e.cap ? 2 : 0)));
                    end
                    last_data <= ctl.rsp_data;
                end else begin
                    check("rsp_stable", 64'(ctl.rsp_data), 64'(last_data));
                end
            end
            prev_v <= ctl.rsp_valid;
        end
    end

    int rises0, caps0, sin_base;

    task automatic send(input logic [PW-1:0] pat, input bit cap);
        int g = 0;
        @(negedge clk);
        while (!ctl.cmd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("cmd_ready_wait", 64'(ctl.cmd_ready), 64'd1);
        ctl.cmd_valid   = 1'b1;
        ctl.cmd_pattern = pat;
        ctl.cmd_capture = cap;
        rises0   = rises;
        caps0    = cap_hi;
        sin_base = rise_sin.size();
        @(posedge clk);
        #1;
        ctl.cmd_valid = 1'b0;
        exp_q.push_back('{{chain[3], chain[2], chain[1], chain[0]}, cyc, cap});
    endtask

    task automatic wait_rsp(output logic [PW-1:0] d);
        int g = 0;
        @(negedge clk);
        while (!ctl.rsp_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("rsp_valid_wait", 64'(ctl.rsp_valid), 64'd1);
        d = ctl.rsp_data;
    endtask

    task automatic run_cmd(input logic [PW-1:0] pat, input bit cap, output logic [PW-1:0] d);
        send(pat, cap);
        wait_rsp(d);
        @(negedge clk);
        check("idle_after_rsp", 64'({ctl.cmd_ready, ctl.rsp_valid, mode_n}), 64'b101);
        check("rise_count", 64'(rises - rises0), 64'(L + (cap ? 1 : 0)));
    endtask

    logic [PW-1:0] d, prev_pat, pat;
    logic [L-1:0]  seq;

    initial begin
        ctl.cmd_valid = 0; ctl.cmd_capture = 0; ctl.cmd_pattern = '0;
        ctl.abort = 0; ctl.rsp_ready = 1;
        rst = 1;
        for (int s = 0; s < 4; s++) preload_val[s] = '0;
        preload_val[0] = 4'b0110;
        preload_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload_en = 1'b0;
        check("reset_outputs", 64'({ctl.cmd_ready, mode_n, shift_n, ctl.rsp_valid, sin, sclk}), 64'b1110_0000_0000);
        check("reset_rsp_data", 64'(ctl.rsp_data), 64'd0);
        rst = 0;

        // Basic shift with no capture.
        run_cmd({12'h000, 4'b1011}, 1'b0, d);
        check("basic_rsp_seg0", 64'(d[3:0]), 64'b0110);
        check("basic_chain0", 64'(chain[0]), 64'b1011);
        check("basic_rise_sin_n", 64'(rise_sin.size() - sin_base), 64'(L));
        if (rise_sin.size() - sin_base == L) begin
            for (int i = 0; i < L; i++) seq[i] = rise_sin[sin_base + i];
            check("basic_rise_sin", 64'(seq), 64'b1011);
        end

        // Capture: one extra shift clock high cycle with shift_n=1.
        run_cmd({12'h000, 4'b1011}, 1'b1, d);
        check("capture_hi_cycles", 64'(cap_hi - caps0), 64'd1);
        check("capture_rsp_seg0", 64'(d[3:0]), 64'b1011);

        // Abort together with cmd_valid in IDLE: not accepted.
        @(negedge clk);
        ctl.cmd_valid = 1; ctl.abort = 1; ctl.cmd_pattern = 16'hFFFF;
        @(negedge clk);
        ctl.cmd_valid = 0; ctl.abort = 0;
        check("abort_wins_idle", 64'({ctl.cmd_ready, mode_n, shift_n}), 64'b111);

        // Randomized back-to-back loopback: each response returns the previous pattern.
        prev_pat = PW'($urandom);
        run_cmd(prev_pat, 1'($urandom_range(0, 1)), d);
        for (int k = 0; k < 6; k++) begin
            pat = PW'($urandom);
            run_cmd(pat, 1'($urandom_range(0, 1)), d);
            check("loopback", 64'(d), 64'(prev_pat));
            prev_pat = pat;
        end

        // Abort in SHIFT at i=2.
        send(PW'($urandom), 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_at_i2_rises", 64'(rises - rises0), 64'd2);
        ctl.abort = 1;
        @(negedge clk);
        ctl.abort = 0;
        void'(exp_q.pop_back());
        check("abort_idle", 64'({ctl.cmd_ready, mode_n, shift_n, ctl.rsp_valid, sclk}), 64'b1110_0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(ctl.rsp_valid), 64'd0);
        end
        run_cmd(PW'($urandom), 1'b0, d);

        // Backpressure: response held, new commands ignored.
        ctl.rsp_ready = 0;
        send(PW'($urandom), 1'($urandom_range(0, 1)));
        wait_rsp(d);
        rises0 = rises;
        for (int k = 0; k < 20; k++) begin
            ctl.cmd_valid   = 1;
            ctl.cmd_pattern = PW'($urandom);
            @(negedge clk);
            check("bp_hold", 64'({ctl.rsp_valid, ctl.cmd_ready}), 64'b10);
        end
        ctl.cmd_valid = 0;
        check("bp_no_shift", 64'(rises - rises0), 64'd0);
        ctl.rsp_ready = 1;
        @(negedge clk);
        check("bp_release", 64'({ctl.cmd_ready, ctl.rsp_valid, mode_n}), 64'b101);

        // Reset mid-operation clears the response data.
        send(PW'($urandom), 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        void'(exp_q.pop_back());
        check("rst_mid_outputs", 64'({ctl.cmd_ready, mode_n, shift_n, ctl.rsp_valid, sin, sclk}), 64'b1110_0000_0000);
        check("rst_mid_data", 64'(ctl.rsp_data), 64'd0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
